mult32x32_ctrl: RTL and testbench

Sequencing FSM for the 32x32 multiplier arithmetic unit. It turns a single start request into the 8-step byte-by-halfword accumulation: 4 bytes of A times 2 halfwords of B. It drives the unit's a_sel, b_sel, shift_sel, upd_prod and clr_prod controls, and reports busy and done to the requester. It sits beside the arithmetic unit inside the top-level 32x32 multiplier.

---
 rtl/mult32x32_ctrl_if.sv | 19 +
 rtl/mult32x32_ctrl.sv | 54 +++++
 tb/tb_mult32x32_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mult32x32_ctrl_if.sv
// mult32x32_ctrl_if: start request plus the arithmetic-unit control and status signals of the multiplier sequencer
interface mult32x32_ctrl_if;
    logic       start;
    logic [1:0] a_sel;
    logic       b_sel;
    logic [2:0] shift_sel;
    logic       upd_prod;
    logic       clr_prod;
    logic       busy;
    logic       done;
    modport master (
        output start,
        input  a_sel, b_sel, shift_sel, upd_prod, clr_prod, busy, done
    );
    modport slave (
        input  start,
        output a_sel, b_sel, shift_sel, upd_prod, clr_prod, busy, done
    );
endinterface

// File: rtl/mult32x32_ctrl.sv
// mult32x32_ctrl: sequences 8 byte-by-halfword accumulate steps of a 32x32 multiply from a single start
module mult32x32_ctrl (
    input logic             clk,
    input logic             reset,
    mult32x32_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;
    state_t     state_q, state_d;
    logic [2:0] k_q, k_d;
    // State and step counter; reset is asynchronous so outputs fall without a clock edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= 3'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end
    // Next state and control decode; clr_prod is Mealy on start so the product clears at the accept edge
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        bus.a_sel     = 2'd0;
        bus.b_sel     = 1'b0;
        bus.shift_sel = 3'd0;
        bus.upd_prod  = 1'b0;
        bus.clr_prod  = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        case (state_q)
            STEP: begin
                bus.a_sel     = k_q[2:1];
                bus.b_sel     = k_q[0];
                bus.shift_sel = {1'b0, k_q[2:1]} + {1'b0, k_q[0], 1'b0};
                bus.upd_prod  = 1'b1;
                bus.busy      = 1'b1;
                state_d       = (k_q == 3'd7) ? DONE : STEP;
                k_d           = (k_q == 3'd7) ? 3'd0 : k_q + 3'd1;
            end
            DONE: begin
                bus.done     = 1'b1;
                bus.clr_prod = bus.start;
                state_d      = bus.start ? STEP : IDLE;
                k_d          = 3'd0;
            end
            default: begin
                bus.clr_prod = bus.start;
                state_d      = bus.start ? STEP : IDLE;
                k_d          = 3'd0;
            end
        endcase
    end
endmodule

// File: tb/tb_mult32x32_ctrl.sv
// tb_mult32x32_ctrl: directed checks of the multiplier sequencer paired with a behavioural arithmetic unit
module tb_mult32x32_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic [63:0] prod;
    int          checks = 0;
    int          errors = 0;
    int          exp_a  [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    int          exp_b  [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    int          exp_sh [8] = '{0, 2, 1, 3, 2, 4, 3, 5};

    mult32x32_ctrl_if bus ();

    mult32x32_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Arithmetic unit: clear or accumulate a selected byte of A times a selected halfword of B, shifted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            prod <= 64'd0;
        else if (bus.clr_prod)
            prod <= 64'd0;
        else if (bus.upd_prod)
            prod <= prod + ((64'((op_a >> (8 * bus.a_sel)) & 32'hFF) *
                             64'((op_b >> (16 * bus.b_sel)) & 32'hFFFF)) << (8 * bus.shift_sel));
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE or DONE; ends at the negedge of the following DONE cycle
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp, input bit hold_mid);
        op_a = a;
        op_b = b;
        bus.start = 1'b1;
        #1;
        chk("accept_clr", bus.clr_prod, 1'b1);
        chk("accept_upd", bus.upd_prod, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            bus.start = hold_mid && (k >= 2) && (k <= 5);
            #1;
            chk($sformatf("step%0d_a_sel", k), bus.a_sel, exp_a[k]);
            chk($sformatf("step%0d_b_sel", k), bus.b_sel, exp_b[k]);
            chk($sformatf("step%0d_shift", k), bus.shift_sel, exp_sh[k]);
            chk($sformatf("step%0d_upd", k), bus.upd_prod, 1'b1);
            chk($sformatf("step%0d_clr", k), bus.clr_prod, 1'b0);
            chk($sformatf("step%0d_busy", k), bus.busy, 1'b1);
            chk($sformatf("step%0d_done", k), bus.done, 1'b0);
            @(negedge clk);
        end
        bus.start = 1'b0;
        #1;
        chk("done_pulse", bus.done, 1'b1);
        chk("done_busy", bus.busy, 1'b0);
        chk("done_upd", bus.upd_prod, 1'b0);
        chk("done_clr", bus.clr_prod, 1'b0);
        chk("product", prod, exp);
    endtask

    initial begin
        bus.start = 1'b0;
        #2;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_upd", bus.upd_prod, 1'b0);
        chk("rst_clr", bus.clr_prod, 1'b0);
        chk("rst_sel", {bus.a_sel, bus.b_sel, bus.shift_sel}, 6'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("idle_busy", bus.busy, 1'b0);
        chk("idle_clr", bus.clr_prod, 1'b0);
        // Basic multiply
        do_op(32'h00010002, 32'h00030004, 64'h00000003000A0008, 1'b0);
        @(negedge clk);
        #1;
        chk("idle_after_done", bus.done, 1'b0);
        chk("idle_after_busy", bus.busy, 1'b0);
        // Max operands
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b0);
        @(negedge clk);
        // Start held while busy, then back-to-back start from DONE
        do_op(32'h00000002, 32'h00000009, 64'd18, 1'b1);
        do_op(32'd5, 32'd7, 64'd35, 1'b0);
        @(negedge clk);
        #1;
        chk("single_done", bus.done, 1'b0);
        // Reset mid-operation, during step 4
        op_a = 32'h01020304;
        op_b = 32'h05060708;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("pre_rst_step4", bus.a_sel, 2'd2);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_done", bus.done, 1'b0);
        chk("midrst_upd", bus.upd_prod, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_op(32'd3, 32'd4, 64'd12, 1'b0);
        @(negedge clk);
        // Zero operand still takes the full sequence
        do_op(32'd0, 32'hDEADBEEF, 64'd0, 1'b0);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
